// File: rtl/dm_pkg.sv
// Shared encodings, response record and alignment helper for the sized data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane handling: merges store data into the old word and
// extracts/extends load data from the addressed lane(s).
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [15:0] low;
  logic        fill;

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

  // Selected lane(s) land at bit 0 before extension.
  assign low = 16'(word >> {lane, 3'b000});

  always_comb begin
    fill  = 1'b0;
    rdata = word;
    case (size)
      SZ_BYTE: begin
        fill  = ~is_unsigned & low[7];
        rdata = {{24{fill}}, low[7:0]};
      end
      SZ_HALF: begin
        fill  = ~is_unsigned & low[15];
        rdata = {{16{fill}}, low[15:0]};
      end
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/dm_sized_sync.sv
// Parametrised data memory: zero-fill after reset, sized stores, extended loads,
// RD_LAT-cycle response pipeline with error reporting.
module dm_sized_sync
  import dm_pkg::*;
#(
  parameter int unsigned AW     = 14,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int unsigned IW = AW - 2;
  localparam int unsigned DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   dm [DEPTH];
  state_e        state;
  state_e        state_n;
  logic [DW-1:0] clear_cnt;
  logic          clear_we;

  logic [IW-1:0] idx;
  logic [DW-1:0] widx;
  logic [1:0]    lane;
  logic          in_range;
  logic          req_err;
  logic          fire;
  logic [31:0]   rd_word;
  logic [31:0]   st_word;
  logic [31:0]   ld_word;
  rsp_t          stage_in;
  rsp_t          pipe [RD_LAT];

  assign idx      = req_addr[AW-1:2];
  assign widx     = idx[DW-1:0];
  assign lane     = req_addr[1:0];
  assign in_range = 32'(idx) < DEPTH;
  assign req_err  = is_misaligned(req_size, lane) | (req_size == SZ_RSVD) | ~in_range;
  // A request coinciding with the reset edge must neither write nor respond.
  assign fire     = req_valid & req_ready & ~rst;
  assign rd_word  = in_range ? dm[widx] : '0;

  dm_lane_fmt u_fmt (
    .word        (rd_word),
    .wdata       (req_wdata),
    .size        (req_size),
    .lane        (lane),
    .is_unsigned (req_unsigned),
    .merged      (st_word),
    .rdata       (ld_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    clear_we  = 1'b0;
    case (state)
      ST_CLEAR: begin
        clear_we = 1'b1;
        if (clear_cnt == DW'(DEPTH - 1)) state_n = ST_RUN;
      end
      ST_RUN:  req_ready = 1'b1;
      default: state_n = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           clear_cnt <= '0;
    else if (clear_we) clear_cnt <= clear_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear_we && !rst)                 dm[clear_cnt] <= '0;
    else if (fire && req_we && !req_err)  dm[widx]      <= st_word;
  end

  always_comb begin
    stage_in       = '0;
    stage_in.valid = fire;
    stage_in.err   = fire & req_err;
    stage_in.rdata = (fire && !req_we && !req_err) ? ld_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_valid = pipe[RD_LAT-1].valid;
  assign rsp_err   = pipe[RD_LAT-1].err;
  assign rsp_rdata = pipe[RD_LAT-1].rdata;

endmodule

// File: tb/tb_dm_sized_sync.sv
// Directed bench: three instances (RD_LAT 1..3) share one request stream; each
// response is checked against a hand-computed expectation and its due cycle.
module tb_dm_sized_sync;
  import dm_pkg::*;

  localparam int unsigned AW    = 14;
  localparam int unsigned DEPTH = 64;

  typedef struct {
    int unsigned due;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          rdy [3];
  logic          rv  [3];
  logic          re  [3];
  logic [31:0]   rd  [3];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned rv_cnt [3] = '{0, 0, 0};
  exp_t        q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_sized_sync #(.AW(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_dm_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));

  dm_sized_sync #(.AW(AW), .DEPTH(DEPTH), .RD_LAT(2)) u_dm_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));

  dm_sized_sync #(.AW(AW), .DEPTH(DEPTH), .RD_LAT(3)) u_dm_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input int k);
    exp_t x;
    if (q[k].size() > 0 && q[k][0].due < cyc) begin
      chk($sformatf("missing_rsp_l%0d", k + 1), 32'(rv[k]), 32'd1);
      void'(q[k].pop_front());
    end
    if (rv[k] === 1'b1) begin
      rv_cnt[k]++;
      if (q[k].size() == 0) begin
        chk($sformatf("spurious_rsp_l%0d", k + 1), 32'(rv[k]), 32'd0);
      end else begin
        x = q[k].pop_front();
        chk($sformatf("latency_l%0d", k + 1), cyc, x.due);
        chk($sformatf("err_l%0d", k + 1), 32'(re[k]), 32'(x.err));
        chk($sformatf("rdata_l%0d", k + 1), rd[k], x.rdata);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  // Drives one request for one edge; leaves valid high so calls chain back-to-back.
  task automatic issue(input logic we, input logic [1:0] sz, input logic [AW-1:0] a,
                       input logic uns, input logic [31:0] wd,
                       input logic e, input logic [31:0] r);
    exp_t x;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_addr     = a;
    req_unsigned = uns;
    req_wdata    = wd;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_l%0d", k + 1), 32'(rdy[k]), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      x.due   = cyc + 32'(k);
      x.err   = e;
      x.rdata = r;
      q[k].push_back(x);
    end
  endtask

  task automatic st(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] wd,
                    input logic e);
    issue(1'b1, sz, a, 1'b0, wd, e, 32'h0);
  endtask

  task automatic ld(input logic [1:0] sz, input logic [AW-1:0] a, input logic uns,
                    input logic e, input logic [31:0] r);
    issue(1'b0, sz, a, uns, 32'h0, e, r);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int unsigned snap [3];
    int unsigned n;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      snap[k] = rv_cnt[k];
      chk($sformatf("rst_ready_l%0d", k + 1), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_valid_l%0d", k + 1), 32'(rv[k]), 32'd0);
      chk($sformatf("rst_rdata_l%0d", k + 1), rd[k], 32'd0);
      chk($sformatf("rst_err_l%0d", k + 1), 32'(re[k]), 32'd0);
    end
    n = 0;
    while (rdy[0] !== 1'b1 && n < DEPTH + 16) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("clear_len", n, DEPTH);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ready_after_clear_l%0d", k + 1), 32'(rdy[k]), 32'd1);
      chk($sformatf("no_rsp_in_clear_l%0d", k + 1), rv_cnt[k] - snap[k], 32'd0);
    end
  endtask

  initial begin
    do_reset();

    // Array zero after clear: first and last word.
    ld(SZ_WORD, 14'h0000, 1'b0, 1'b0, 32'h0000_0000);
    ld(SZ_WORD, 14'((DEPTH - 1) * 4), 1'b0, 1'b0, 32'h0000_0000);
    idle(4);

    // Byte/half sign and zero extension.
    st(SZ_WORD, 14'h0010, 32'h80FF_7F01, 1'b0);
    ld(SZ_BYTE, 14'h0011, 1'b0, 1'b0, 32'h0000_007F);
    ld(SZ_BYTE, 14'h0012, 1'b0, 1'b0, 32'hFFFF_FFFF);
    ld(SZ_BYTE, 14'h0013, 1'b1, 1'b0, 32'h0000_0080);
    ld(SZ_HALF, 14'h0012, 1'b0, 1'b0, 32'hFFFF_80FF);
    ld(SZ_HALF, 14'h0010, 1'b1, 1'b0, 32'h0000_7F01);
    idle(4);

    // Partial stores merged, load immediately after the last store.
    st(SZ_WORD, 14'h0020, 32'h1122_3344, 1'b0);
    st(SZ_HALF, 14'h0022, 32'h0000_BEEF, 1'b0);
    st(SZ_BYTE, 14'h0020, 32'h0000_00AA, 1'b0);
    ld(SZ_WORD, 14'h0020, 1'b0, 1'b0, 32'hBEEF_33AA);
    idle(4);

    // Error cases: no write, err set, rdata zero; then reload.
    st(SZ_HALF, 14'h0021, 32'h0000_DEAD, 1'b1);
    st(SZ_WORD, 14'h0022, 32'hFFFF_FFFF, 1'b1);
    st(SZ_RSVD, 14'h0020, 32'h1234_5678, 1'b1);
    ld(SZ_WORD, 14'h0022, 1'b0, 1'b1, 32'h0);
    ld(SZ_RSVD, 14'h0020, 1'b0, 1'b1, 32'h0);
    st(SZ_WORD, 14'(DEPTH * 4), 32'hCAFE_F00D, 1'b1);
    ld(SZ_WORD, 14'(DEPTH * 4), 1'b0, 1'b1, 32'h0);
    ld(SZ_WORD, 14'h0020, 1'b0, 1'b0, 32'hBEEF_33AA);
    ld(SZ_BYTE, 14'h0021, 1'b0, 1'b0, 32'h0000_0033);
    ld(SZ_WORD, 14'((DEPTH - 1) * 4), 1'b0, 1'b0, 32'h0000_0000);
    idle(4);

    // Eight back-to-back mixed requests.
    st(SZ_BYTE, 14'h0030, 32'h0000_005A, 1'b0);
    ld(SZ_BYTE, 14'h0030, 1'b1, 1'b0, 32'h0000_005A);
    st(SZ_HALF, 14'h0032, 32'h0000_8001, 1'b0);
    ld(SZ_HALF, 14'h0032, 1'b0, 1'b0, 32'hFFFF_8001);
    ld(SZ_WORD, 14'h0030, 1'b0, 1'b0, 32'h8001_005A);
    ld(SZ_HALF, 14'h0033, 1'b0, 1'b1, 32'h0);
    ld(SZ_WORD, 14'h0010, 1'b0, 1'b0, 32'h80FF_7F01);
    ld(SZ_HALF, 14'h0032, 1'b1, 1'b0, 32'h0000_8001);
    idle(5);
    for (int k = 0; k < 3; k++) chk($sformatf("drained_l%0d", k + 1), 32'(q[k].size()), 32'd0);

    // Reset with loads in flight: pending responses dropped, array cleared again.
    ld(SZ_WORD, 14'h0010, 1'b0, 1'b0, 32'h80FF_7F01);
    ld(SZ_WORD, 14'h0020, 1'b0, 1'b0, 32'hBEEF_33AA);
    ld(SZ_WORD, 14'h0030, 1'b0, 1'b0, 32'h8001_005A);
    do_reset();
    ld(SZ_WORD, 14'h0010, 1'b0, 1'b0, 32'h0000_0000);
    ld(SZ_WORD, 14'h0020, 1'b0, 1'b0, 32'h0000_0000);
    idle(6);
    for (int k = 0; k < 3; k++) chk($sformatf("final_drain_l%0d", k + 1), 32'(q[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
